// File: rtl/generador_pulsos.sv
// generador_pulsos: emits a train of N clean pulses on an output pin.
// Fixed high width and low gap, both set in milliseconds.
module generador_pulsos #(
  parameter int unsigned CICLOS_MS = 50000,
  parameter int unsigned ANCHO_MS  = 20,
  parameter int unsigned PAUSA_MS  = 20,
  parameter int unsigned N_BITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disparo,
  input  logic [N_BITS-1:0] cantidad,
  output logic              salida,
  output logic              ocupado,
  output logic              fin
);

  localparam logic [31:0] CA = 32'(CICLOS_MS * ANCHO_MS);
  localparam logic [31:0] CP = 32'(CICLOS_MS * PAUSA_MS);
  localparam logic [31:0] CA_UL = CA - 32'd1;
  localparam logic [31:0] CP_UL = CP - 32'd1;
  localparam logic [N_BITS-1:0] UNO = N_BITS'(1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    ALTO   = 2'd1,
    BAJO   = 2'd2
  } estado_t;

  estado_t           estado;
  logic [31:0]       ciclos;
  logic [N_BITS-1:0] restantes;

  // Outputs are set together with the state they belong to, so they
  // come straight from flops and line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado    <= REPOSO;
      ciclos    <= '0;
      restantes <= '0;
      salida    <= 1'b0;
      ocupado   <= 1'b0;
      fin       <= 1'b0;
    end else begin
      fin <= 1'b0;
      unique case (estado)
        REPOSO: begin
          salida  <= 1'b0;
          ocupado <= 1'b0;
          if (disparo && (cantidad != '0)) begin
            restantes <= cantidad;
            ciclos    <= '0;
            estado    <= ALTO;
            salida    <= 1'b1;
            ocupado   <= 1'b1;
          end
        end
        ALTO: begin
          if (ciclos == CA_UL) begin
            restantes <= restantes - UNO;
            ciclos    <= '0;
            estado    <= BAJO;
            salida    <= 1'b0;
          end else begin
            ciclos <= ciclos + 32'd1;
          end
        end
        BAJO: begin
          if (ciclos == CP_UL) begin
            ciclos <= '0;
            if (restantes != '0) begin
              estado <= ALTO;
              salida <= 1'b1;
            end else begin
              // Trailing gap done: release and strobe completion.
              estado  <= REPOSO;
              ocupado <= 1'b0;
              fin     <= 1'b1;
            end
          end else begin
            ciclos <= ciclos + 32'd1;
          end
        end
        default: begin
          estado  <= REPOSO;
          ciclos  <= '0;
          salida  <= 1'b0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_pulsos.sv
// Directed-vector bench for generador_pulsos with CA=4, CP=2.
// Each vector: inputs applied before an edge, outputs checked after it.
module tb_generador_pulsos;

  logic       clk;
  logic       rst;
  logic       disparo;
  logic [3:0] cantidad;
  logic       salida;
  logic       ocupado;
  logic       fin;

  int errors = 0;
  int checks = 0;

  generador_pulsos #(
    .CICLOS_MS(2),
    .ANCHO_MS (2),
    .PAUSA_MS (1),
    .N_BITS   (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .disparo (disparo),
    .cantidad(cantidad),
    .salida  (salida),
    .ocupado (ocupado),
    .fin     (fin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       disparo;
    logic [3:0] cantidad;
    logic       salida;
    logic       ocupado;
    logic       fin;
  } vec_t;

  vec_t tabla[$];

  function automatic vec_t mk(input logic r, input logic d,
                              input logic [3:0] c, input logic s,
                              input logic o, input logic f);
    vec_t v;
    v.rst = r;
    v.disparo = d;
    v.cantidad = c;
    v.salida = s;
    v.ocupado = o;
    v.fin = f;
    return v;
  endfunction

  function automatic void add(input logic r, input logic d,
                              input logic [3:0] c, input logic s,
                              input logic o, input logic f);
    tabla.push_back(mk(r, d, c, s, o, f));
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++) add(0, 0, 4'd0, 0, 0, 0);
  endfunction

  // Expected train of n pulses: 4 high, 2 low each, then one fin cycle.
  // Returns the table index of the accepting vector.
  function automatic int tren(input int n);
    int start;
    start = tabla.size();
    add(0, 1, 4'(n), 1, 1, 0);
    for (int k = 0; k < n; k++) begin
      for (int h = 0; h < ((k == 0) ? 3 : 4); h++) add(0, 0, 4'd9, 1, 1, 0);
      for (int l = 0; l < 2; l++) add(0, 0, 4'd9, 0, 1, 0);
    end
    add(0, 0, 4'd0, 0, 0, 1);
    return start;
  endfunction

  task automatic aplicar(input vec_t v, input string nombre);
    @(negedge clk);
    rst = v.rst;
    disparo = v.disparo;
    cantidad = v.cantidad;
    @(posedge clk);
    #1;
    checks++;
    if ({salida, ocupado, fin} !== {v.salida, v.ocupado, v.fin}) begin
      errors++;
      $display("FAIL %s: salida/ocupado/fin got %b%b%b required %b%b%b",
               nombre, salida, ocupado, fin, v.salida, v.ocupado, v.fin);
    end
  endtask

  task automatic correr_tabla(input string pref);
    for (int i = 0; i < tabla.size(); i++)
      aplicar(tabla[i], $sformatf("%s[%0d]", pref, i));
  endtask

  task automatic chequeo(input string nombre, input logic [2:0] req);
    checks++;
    if ({salida, ocupado, fin} !== req) begin
      errors++;
      $display("FAIL %s: salida/ocupado/fin got %b%b%b required %b",
               nombre, salida, ocupado, fin, req);
    end
  endtask

  initial begin
    int s;
    rst = 1'b1;
    disparo = 1'b0;
    cantidad = 4'd0;

    // Reset held, disparo toggling
    add(1, 1, 4'd3, 0, 0, 0);
    add(1, 0, 4'd3, 0, 0, 0);
    add(1, 1, 4'd1, 0, 0, 0);
    add(1, 0, 4'd0, 0, 0, 0);
    idle(2);
    // Single pulse
    s = tren(1);
    idle(2);
    // Three pulses
    s = tren(3);
    idle(1);
    // cantidad = 0 ignored, then max train
    add(0, 1, 4'd0, 0, 0, 0);
    idle(3);
    s = tren(15);
    idle(2);
    // Requests during a 2-pulse train: mid-ALTO and mid-BAJO
    s = tren(2);
    tabla[s + 2].disparo = 1'b1;
    tabla[s + 2].cantidad = 4'd5;
    tabla[s + 10].disparo = 1'b1;
    tabla[s + 10].cantidad = 4'd5;
    // Back-to-back: next disparo sampled in the fin cycle
    s = tren(1);
    s = tren(2);
    idle(3);

    correr_tabla("vec");

    // Reset in cycle 2 of the second pulse of a 3-pulse train
    aplicar(mk(0, 1, 4'd3, 1, 1, 0), "rst_mid.start");
    for (int i = 0; i < 3; i++) aplicar(mk(0, 0, 4'd0, 1, 1, 0), "rst_mid.hi0");
    for (int i = 0; i < 2; i++) aplicar(mk(0, 0, 4'd0, 0, 1, 0), "rst_mid.lo0");
    for (int i = 0; i < 2; i++) aplicar(mk(0, 0, 4'd0, 1, 1, 0), "rst_mid.hi1");
    #2;
    rst = 1'b1;
    #1;
    chequeo("rst_mid.async", 3'b000);
    aplicar(mk(1, 0, 4'd0, 0, 0, 0), "rst_mid.hold");
    aplicar(mk(1, 0, 4'd0, 0, 0, 0), "rst_mid.hold");
    for (int i = 0; i < 14; i++) aplicar(mk(0, 0, 4'd0, 0, 0, 0), "rst_mid.nofin");

    tabla.delete();
    s = tren(1);
    idle(2);
    correr_tabla("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
